// File: rtl/vnlp_pkg.sv
// Shared definitions for the vector norm processor list writer: sizes, float
// field slices, node header layout and the writer state encoding.
package vnlp_pkg;

    localparam int word_size   = 24;
    localparam int len_size    = 8;
    localparam int memory_size = 512;
    localparam int addr_size   = 9;

    localparam int SIGN_BIT = 23;
    localparam int EXP_HI   = 22;
    localparam int EXP_LO   = 15;
    localparam int MAN_HI   = 14;
    localparam int MAN_LO   = 0;

    // Node layout: next pointer, element count, then the elements
    localparam int NEXT_OFS = 0;
    localparam int LEN_OFS  = 1;
    localparam int ELEM_OFS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_LEN,
        S_LINK,
        S_NEXT,
        S_TERM,
        S_DONE
    } wr_state_e;

    function automatic logic is_zero_mag(input logic [word_size-1:0] w);
        return (w[EXP_HI:EXP_LO] == '0) && (w[MAN_HI:MAN_LO] == '0);
    endfunction

    // A zero magnitude already has all-zero low bits, so only the sign needs clearing
    function automatic logic [word_size-1:0] canon_zero(input logic [word_size-1:0] w);
        return {w[SIGN_BIT] & ~is_zero_mag(w), w[EXP_HI:MAN_LO]};
    endfunction

endpackage

// File: rtl/vnlp_addr_check.sv
// Combinational address helper: element/next-node address (node+2+count) and
// length-word address, each with a flag saying it lies inside the memory.
module vnlp_addr_check
    import vnlp_pkg::*;
(
    input  logic [addr_size-1:0] node,
    input  logic [len_size-1:0]  count,
    output logic [addr_size-1:0] elem_addr,
    output logic                 elem_ok,
    output logic [addr_size-1:0] len_addr,
    output logic                 len_ok
);

    localparam int WIDE = addr_size + 1;

    // One extra bit so that sums past the top of memory are seen, not wrapped
    logic [WIDE-1:0] elem_sum;
    logic [WIDE-1:0] len_sum;

    always_comb begin
        elem_sum = WIDE'(node) + WIDE'(ELEM_OFS) + WIDE'(count);
        len_sum  = WIDE'(node) + WIDE'(LEN_OFS);
    end

    assign elem_addr = elem_sum[addr_size-1:0];
    assign elem_ok   = elem_sum < WIDE'(memory_size);
    assign len_addr  = len_sum[addr_size-1:0];
    assign len_ok    = len_sum < WIDE'(memory_size);

endmodule

// File: rtl/vnlp_list_writer.sv
// Streams float elements into operand memory as a linked list of vector nodes.
// Optional VNLP_WR_CANON_ZERO_EN: elements of zero magnitude are written as +0.
module vnlp_list_writer
    import vnlp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] base_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_last,
    input  logic                 in_eol,
    output logic                 mem_we,
    output logic [addr_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [addr_size-1:0] head_addr,
    output logic [len_size-1:0]  vec_count
);

    localparam logic [len_size-1:0] LEN_MAX = '1;

    wr_state_e            state_q, state_d;
    logic [addr_size-1:0] node_q, node_d;
    logic [addr_size-1:0] prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [len_size-1:0]  count_q, count_d;
    logic                 eol_q, eol_d;
    logic                 err_q, err_d;
    logic [addr_size-1:0] head_q, head_d;
    logic [len_size-1:0]  vec_q, vec_d;
    logic                 we_q, we_d;
    logic [addr_size-1:0] addr_q, addr_d;
    logic [word_size-1:0] wdata_q, wdata_d;
    logic                 done_q, done_d;

    logic [addr_size-1:0] elem_addr;
    logic                 elem_ok;
    logic [addr_size-1:0] len_addr;
    logic                 len_ok;
    logic [word_size-1:0] elem_word;

    vnlp_addr_check u_addr_check (
        .node      (node_q),
        .count     (count_q),
        .elem_addr (elem_addr),
        .elem_ok   (elem_ok),
        .len_addr  (len_addr),
        .len_ok    (len_ok)
    );

`ifdef VNLP_WR_CANON_ZERO_EN
    assign elem_word = canon_zero(in_data);
`else
    assign elem_word = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            node_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            count_q      <= '0;
            eol_q        <= 1'b0;
            err_q        <= 1'b0;
            head_q       <= '0;
            vec_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            node_q       <= node_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            count_q      <= count_d;
            eol_q        <= eol_d;
            err_q        <= err_d;
            head_q       <= head_d;
            vec_q        <= vec_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        node_d       = node_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        count_d      = count_q;
        eol_d        = eol_q;
        err_d        = err_q;
        head_d       = head_q;
        vec_d        = vec_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    node_d       = base_addr;
                    head_d       = base_addr;
                    err_d        = 1'b0;
                    vec_d        = '0;
                    prev_valid_d = 1'b0;
                    count_d      = '0;
                    state_d      = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    // A 256th element or a write past the top of memory aborts the list
                    if (count_q == LEN_MAX || !elem_ok) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = elem_addr;
                        wdata_d = elem_word;
                        count_d = count_q + len_size'(1);
                        if (in_last) begin
                            eol_d   = in_eol;
                            state_d = S_LEN;
                        end
                    end
                end
            end
            S_LEN: begin
                if (!len_ok) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = len_addr;
                    wdata_d = word_size'(count_q);
                    if (prev_valid_q)  state_d = S_LINK;
                    else if (eol_q)    state_d = S_TERM;
                    else               state_d = S_NEXT;
                end
            end
            S_LINK: begin
                we_d    = 1'b1;
                addr_d  = addr_size'(prev_q + addr_size'(NEXT_OFS));
                wdata_d = word_size'(node_q);
                state_d = eol_q ? S_TERM : S_NEXT;
            end
            S_NEXT: begin
                // The next node must start inside memory or its header could never be written
                if (!elem_ok) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    prev_d       = node_q;
                    node_d       = elem_addr;
                    count_d      = '0;
                    prev_valid_d = 1'b1;
                    vec_d        = vec_q + len_size'(1);
                    state_d      = S_DATA;
                end
            end
            S_TERM: begin
                we_d    = 1'b1;
                addr_d  = addr_size'(node_q + addr_size'(NEXT_OFS));
                wdata_d = '0;
                vec_d   = vec_q + len_size'(1);
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_DATA);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign head_addr = head_q;
    assign vec_count = vec_q;

endmodule
